// File: rtl/axi_sram_slave_if.sv
// rtl/axi_sram_slave_if.sv - AXI-style bus bundle for the single-port SRAM slave
interface axi_sram_slave_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - one-transaction-at-a-time AXI burst slave over a synchronous SRAM
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_sram_slave_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR_DATA, WR_RESP} state_t;

  state_t                state_q, state_d;
  logic                  ready_en_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [1:0]            burst_q;
  logic [3:0]            cnt_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic awready, arready, wready, bvalid, rvalid, rlast;
  logic aw_hs, ar_hs, w_hs, r_hs, last_beat, rd_en;
  logic [ADDR_WIDTH-1:0] addr_next, rd_addr;
  logic unused_addr_bits;

  // WRAP relies on len+1 being a power of two, so len itself is the low-bit mask.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [3:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] inc;
    mask = ADDR_WIDTH'(len);
    inc  = a + ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  assign last_beat = (cnt_q == len_q);
  assign addr_next = next_addr(addr_q, len_q, burst_q);
  assign aw_hs     = awready && bus.awvalid;
  assign ar_hs     = arready && bus.arvalid;
  assign w_hs      = wready && bus.wvalid;
  assign r_hs      = rvalid && bus.rready;
  assign rd_en     = ar_hs || (r_hs && !last_beat);
  assign rd_addr   = ar_hs ? bus.araddr[ADDR_WIDTH+1:2] : addr_next;

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (state_q)
      IDLE: begin
        awready = ready_en_q;
        arready = ready_en_q && !bus.awvalid;
        if (bus.awvalid && awready)      state_d = WR_DATA;
        else if (bus.arvalid && arready) state_d = RD;
      end
      RD: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        if (bus.rready && last_beat) state_d = IDLE;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (bus.wvalid && last_beat) state_d = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bus.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ready_en_q keeps the IDLE readies low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (aw_hs) begin
        id_q    <= bus.awid;
        addr_q  <= bus.awaddr[ADDR_WIDTH+1:2];
        len_q   <= bus.awlen;
        burst_q <= bus.awburst;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else if (ar_hs) begin
        id_q    <= bus.arid;
        addr_q  <= bus.araddr[ADDR_WIDTH+1:2];
        len_q   <= bus.arlen;
        burst_q <= bus.arburst;
        cnt_q   <= '0;
      end
      if (w_hs) begin
        cnt_q  <= cnt_q + 4'd1;
        addr_q <= addr_next;
        err_q  <= err_q | (bus.wlast != last_beat);
      end
      if (r_hs) begin
        cnt_q  <= cnt_q + 4'd1;
        addr_q <= addr_next;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[addr_q][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
    if (rd_en) rdata_q <= mem[rd_addr];
  end

  assign bus.awready = awready;
  assign bus.arready = arready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bid     = id_q;
  assign bus.bresp   = {err_q, 1'b0};
  assign bus.rvalid  = rvalid;
  assign bus.rlast   = rlast;
  assign bus.rid     = id_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = 2'b00;

  assign unused_addr_bits = ^{bus.awaddr[31:ADDR_WIDTH+2], bus.awaddr[1:0],
                              bus.araddr[31:ADDR_WIDTH+2], bus.araddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed and randomized bench with a word-array reference model
module tb_axi_sram_slave;

  logic aclk;
  logic aresetn;
  int   tests;
  int   fails;

  logic [31:0] model_mem [0:4095];
  logic [31:0] wd [0:15];
  logic [3:0]  ws [0:15];

  axi_sram_slave_if #(.ID_WIDTH(4)) bus ();

  axi_sram_slave #(.ADDR_WIDTH(12), .ID_WIDTH(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word index visited on beat i of a burst, straight from the burst rules.
  function automatic int beat_idx(input int base, input int len, input int burst, input int i);
    int n;
    int start;
    n = len + 1;
    case (burst)
      0: return base;
      2: begin
        start = (base / n) * n;
        return start + ((base - start + i) % n);
      end
      default: return (base + i) % 4096;
    endcase
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input int burst,
                          input int id, input int bad_beat);
    int   n;
    int   idx;
    logic wl;
    logic err;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awlen   = len[3:0];
    bus.awburst = burst[1:0];
    bus.awid    = id[3:0];
    n = 0;
    do begin
      @(negedge aclk);
      n++;
      if (bus.arvalid) chk("ar_blocked_aw", bus.arready, 1'b0);
    end while (!bus.awready && n < 100);
    chk("awready", bus.awready, 1'b1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wl = (bad_beat >= 0) ? (i == bad_beat) : (i == len);
      if (wl != (i == len)) err = 1'b1;
      bus.wvalid = 1'b1;
      bus.wdata  = wd[i];
      bus.wstrb  = ws[i];
      bus.wlast  = wl;
      n = 0;
      do begin
        @(negedge aclk);
        n++;
        if (bus.arvalid) chk("ar_blocked_w", bus.arready, 1'b0);
      end while (!bus.wready && n < 100);
      chk("wready", bus.wready, 1'b1);
      idx = beat_idx(int'(addr[13:2]), len, burst, i);
      for (int b = 0; b < 4; b++) begin
        if (ws[i][b]) model_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    @(negedge aclk);
    chk("bvalid", bus.bvalid, 1'b1);
    chk("bid", bus.bid, id[3:0]);
    chk("bresp", bus.bresp, err ? 2'b10 : 2'b00);
    if (bus.arvalid) chk("ar_blocked_b", bus.arready, 1'b0);
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  // rmode: 0 rready held high, 1 toggling every cycle, 2 random
  task automatic do_read(input logic [31:0] addr, input int len, input int burst,
                         input int id, input int rmode);
    int n;
    int beat;
    int cyc;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = len[3:0];
    bus.arburst = burst[1:0];
    bus.arid    = id[3:0];
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!bus.arready && n < 100);
    chk("arready", bus.arready, 1'b1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 200) begin
      bus.rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? logic'(cyc % 2) : logic'($urandom_range(0, 3) != 0);
      @(negedge aclk);
      chk("rvalid", bus.rvalid, 1'b1);
      chk("rdata", bus.rdata, model_mem[beat_idx(int'(addr[13:2]), len, burst, beat)]);
      chk("rid", bus.rid, id[3:0]);
      chk("rlast", bus.rlast, logic'(beat == len));
      chk("rresp", bus.rresp, 2'b00);
      if (bus.rready) beat++;
      @(posedge aclk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    chk("read_beats", beat, len + 1);
    @(negedge aclk);
    chk("rvalid_done", bus.rvalid, 1'b0);
    chk("arready_idle", bus.arready, 1'b1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int burst;
    int base;
    int bad;
    int n;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 4096; i++) model_mem[i] = '0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    aresetn = 1'b0;

    repeat (3) @(negedge aclk);
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_wready", bus.wready, 1'b0);
    chk("rst_bvalid", bus.bvalid, 1'b0);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_rlast", bus.rlast, 1'b0);
    chk("rst_bresp", bus.bresp, 2'b00);
    chk("rst_bid", bus.bid, 4'd0);
    chk("rst_rid", bus.rid, 4'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rel_awready", bus.awready, 1'b1);
    chk("rel_arready", bus.arready, 1'b1);
    @(posedge aclk); #1;

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'hF;
      end
      do_write(32'(k * 64), 15, 1, k, -1);
    end

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h100, 0, 1, 3, -1);
    do_read(32'h100, 0, 1, 5, 0);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(32'h104, 0, 1, 1, -1);
    wd[0] = 32'h0000AA00; ws[0] = 4'b0010;
    do_write(32'h104, 0, 1, 2, -1);
    do_read(32'h104, 0, 1, 6, 0);
    chk("merge_value", bus.rdata, 32'h1122AA44);

    do_read(32'h200, 3, 1, 7, 1);

    wd[0] = $urandom; ws[0] = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 32'h120; bus.arlen = 4'd0; bus.arburst = 2'b01; bus.arid = 4'd4;
    do_write(32'h120, 0, 1, 8, -1);
    do_read(32'h120, 0, 1, 4, 0);

    do_read(32'h38, 3, 2, 2, 2);
    wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h40, 1, 1, 9, 0);
    do_read(32'h40, 1, 1, 9, 0);

    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
    do_write(32'h3FF8, 3, 1, 10, -1);
    do_read(32'h3FF8, 3, 1, 11, 2);

    for (int t = 0; t < 24; t++) begin
      burst = $urandom_range(0, 2);
      len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
      base  = $urandom_range(0, 240);
      bad   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom);
      end
      do_write(32'(base * 4) | 32'($urandom_range(0, 3)), len, burst, t % 16, bad);
      do_read(32'(base * 4), len, burst, (t + 5) % 16, 2);
    end

    bus.arvalid = 1'b1; bus.araddr = 32'h300; bus.arlen = 4'd7; bus.arburst = 2'b01; bus.arid = 4'd12;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!bus.arready && n < 100);
    chk("rst_test_arready", bus.arready, 1'b1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      chk("pre_rst_rdata", bus.rdata, model_mem[192 + i]);
      @(posedge aclk); #1;
    end
    #1;
    aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", bus.rvalid, 1'b0);
    chk("midrst_rlast", bus.rlast, 1'b0);
    chk("midrst_arready", bus.arready, 1'b0);
    chk("midrst_awready", bus.awready, 1'b0);
    chk("midrst_rid", bus.rid, 4'd0);
    bus.rready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("postrst_arready", bus.arready, 1'b1);
    chk("postrst_rvalid", bus.rvalid, 1'b0);
    @(posedge aclk); #1;
    do_read(32'h300, 7, 1, 13, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, giving word-index width; the memory holds 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter ID_WIDTH, default 4, giving the width of all ID ports.
REQ-003 aclk  in  1  single clock; all state changes on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 awid  in  ID_WIDTH  write transaction ID.
REQ-006 awaddr  in  32  write byte address; word index = awaddr[ADDR_WIDTH+1:2].
REQ-007 awlen  in  4  write beats minus 1.
REQ-008 awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-009 awvalid/awready  in/out  1 each  AW handshake.
REQ-010 wdata  in  32  write data.
REQ-011 wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-012 wlast  in  1  master's last-beat marker.
REQ-013 wvalid/wready  in/out  1 each  W handshake.
REQ-014 bid  out  ID_WIDTH  equals the captured awid.
REQ-015 bresp  out  2  00 OKAY or 10 SLVERR.
REQ-016 bvalid/bready  out/in  1 each  B handshake.
REQ-017 arid  in  ID_WIDTH  read transaction ID.
REQ-018 araddr  in  32  read byte address; same word-index rule as awaddr.
REQ-019 arlen  in  4  read beats minus 1.
REQ-020 arburst  in  2  same encoding as awburst.
REQ-021 arvalid/arready  in/out  1 each  AR handshake.
REQ-022 rid  out  ID_WIDTH  equals the captured arid.
REQ-023 rdata  out  32  read data.
REQ-024 rresp  out  2  always 00.
REQ-025 rlast  out  1  high on the final read beat.
REQ-026 rvalid/rready  out/in  1 each  R handshake.

Function
REQ-027 SHALL implement the FSM IDLE, RD, WR_DATA, WR_RESP, with exactly one transaction in service at a time.
REQ-028 In IDLE: awready=1 and arready=!awvalid, so writes win a simultaneous request.
- AW handshake -> WR_DATA.
- AR handshake -> RD.
- awid/arid, address, len and burst are captured on the handshake.
REQ-029 In RD: rvalid SHALL rise the cycle after the AR handshake.
- On each rvalid&&rready, advance the beat counter and address.
- With rready held high, one beat per cycle, no bubbles.
- While rvalid&&!rready, rdata, rid and rlast hold stable.
- After the rlast handshake -> IDLE.
REQ-030 The memory SHALL use a synchronous 1-cycle read.
- Read address is issued on the AR handshake and on each non-last R handshake.
- Memory output is not re-read while stalled.
REQ-031 In WR_DATA: wready=1.
- Each W handshake writes the bytes enabled by wstrb to the current word, then advances.
- The beat where counter==len ends the burst -> WR_RESP.
REQ-032 The burst length SHALL be set by awlen only; wlast is checked, not obeyed.
- If any beat's wlast != (counter==len), the response is bresp=10.
- Otherwise bresp=00.
REQ-033 In WR_RESP: bvalid=1 until bready, then -> IDLE.
- bvalid SHALL rise the cycle after the last W handshake.
REQ-034 Address update per beat:
- FIXED: unchanged.
- INCR: word index +1, wrapping modulo 2^ADDR_WIDTH.
- WRAP: low log2(len+1) index bits increment modulo (len+1); upper bits fixed.
- WRAP is defined only for len 1, 3, 7, 15; reserved burst 11 behaves as INCR.
REQ-035 Address bits [1:0] and bits above ADDR_WIDTH+1 SHALL be ignored (aliasing permitted).

Reset
REQ-036 aresetn low SHALL immediately, including mid-burst:
- force IDLE;
- drive awready, wready, arready, bvalid, rvalid, rlast low and bresp, rresp, bid, rid to 0;
- clear counters and error flag;
- leave memory contents unchanged.
REQ-037 After reset release, the first rising edge SHALL present IDLE handshake values.

Verification
REQ-038 Write 0x100 data 0xDEADBEEF strb F id 3 -> bid 3, bresp 00; read 0x100 len 0 id 5 -> rdata 0xDEADBEEF, rid 5, rlast 1, rresp 00.
REQ-039 Write 0x11223344 strb F, then 0x0000AA00 strb 0010 -> readback 0x1122AA44.
REQ-040 INCR read len 3 from 0x200 with rready toggling every cycle -> 4 beats of 0x200..0x20C; data stable during stalls; rlast only on beat 4.
REQ-041 arvalid and awvalid in the same IDLE cycle -> AW accepted first; AR accepted only after the B handshake; read returns the new data.
REQ-042 WRAP read len 3 at 0x38 -> words 0x38, 0x3C, 0x30, 0x34; write len 1 with wlast on beat 1 -> bresp 10, 2 beats written.
REQ-043 aresetn pulsed low during beat 2 of a len-7 read -> rvalid 0 immediately; after release arready=1 and a new read returns correct data.
